// File: rtl/inst_queue.sv
// Instruction queue between fetcher and dispatcher: predecodes each instruction
// on push and presents the decoded head entry to dispatch.
module inst_queue #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              fet_issue_in,
    input  logic [31:0]       fet_inst_in,
    input  logic [31:0]       fet_pc_in,
    input  logic [31:0]       fet_predict_pc_in,
    output logic              fet_full_out,
    output logic              fet_almost_full_out,
    input  logic              clear_in,
    input  logic              dis_ready_in,
    output logic              dis_valid_out,
    output logic [31:0]       dis_inst_out,
    output logic [31:0]       dis_pc_out,
    output logic [31:0]       dis_predict_pc_out,
    output logic [31:0]       dis_imm_out,
    output logic [2:0]        dis_class_out,
    output logic [4:0]        dis_rs1_out,
    output logic [4:0]        dis_rs2_out,
    output logic [4:0]        dis_rd_out,
    output logic              dis_occupy_rd_out,
    output logic              dis_illegal_out,
    output logic [PTR_W:0]    count_out
);

    typedef enum logic [2:0] {
        CLS_OP     = 3'd0,
        CLS_OP_IMM = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_BRANCH = 3'd4,
        CLS_JAL    = 3'd5,
        CLS_JALR   = 3'd6,
        CLS_UPPER  = 3'd7
    } inst_class_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] predict_pc;
        logic [31:0] imm;
        inst_class_e cls;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        illegal;
    } entry_t;

    localparam logic [PTR_W:0] FULL_CNT  = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] AFULL_CNT = (PTR_W+1)'(DEPTH - 1);

    entry_t           mem [DEPTH];
    entry_t           dec;
    entry_t           head_ent;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic             full;
    logic             valid;
    logic             push;
    logic             pop;

    logic [6:0]       opc;
    logic [4:0]       f_rs1;
    logic [4:0]       f_rs2;
    logic [4:0]       f_rd;
    logic [31:0]      imm_i;
    logic [31:0]      imm_s;
    logic [31:0]      imm_b;
    logic [31:0]      imm_u;
    logic [31:0]      imm_j;

    assign opc   = fet_inst_in[6:0];
    assign f_rd  = fet_inst_in[11:7];
    assign f_rs1 = fet_inst_in[19:15];
    assign f_rs2 = fet_inst_in[24:20];
    assign imm_i = {{20{fet_inst_in[31]}}, fet_inst_in[31:20]};
    assign imm_s = {{20{fet_inst_in[31]}}, fet_inst_in[31:25], fet_inst_in[11:7]};
    assign imm_b = {{19{fet_inst_in[31]}}, fet_inst_in[31], fet_inst_in[7],
                    fet_inst_in[30:25], fet_inst_in[11:8], 1'b0};
    assign imm_u = {fet_inst_in[31:12], 12'h000};
    assign imm_j = {{11{fet_inst_in[31]}}, fet_inst_in[31], fet_inst_in[19:12],
                    fet_inst_in[20], fet_inst_in[30:21], 1'b0};

    // Register fields are masked here so dispatch never sees stray indices.
    always_comb begin
        dec            = '0;
        dec.inst       = fet_inst_in;
        dec.pc         = fet_pc_in;
        dec.predict_pc = fet_predict_pc_in;
        case (opc)
            7'b0110011: begin
                dec.cls = CLS_OP;
                dec.rs1 = f_rs1;
                dec.rs2 = f_rs2;
                dec.rd  = f_rd;
            end
            7'b0010011: begin
                dec.cls = CLS_OP_IMM;
                dec.imm = imm_i;
                dec.rs1 = f_rs1;
                dec.rd  = f_rd;
            end
            7'b0000011: begin
                dec.cls = CLS_LOAD;
                dec.imm = imm_i;
                dec.rs1 = f_rs1;
                dec.rd  = f_rd;
            end
            7'b0100011: begin
                dec.cls = CLS_STORE;
                dec.imm = imm_s;
                dec.rs1 = f_rs1;
                dec.rs2 = f_rs2;
            end
            7'b1100011: begin
                dec.cls = CLS_BRANCH;
                dec.imm = imm_b;
                dec.rs1 = f_rs1;
                dec.rs2 = f_rs2;
            end
            7'b1101111: begin
                dec.cls = CLS_JAL;
                dec.imm = imm_j;
                dec.rd  = f_rd;
            end
            7'b1100111: begin
                dec.cls = CLS_JALR;
                dec.imm = imm_i;
                dec.rs1 = f_rs1;
                dec.rd  = f_rd;
            end
            7'b0110111, 7'b0010111: begin
                dec.cls = CLS_UPPER;
                dec.imm = imm_u;
                dec.rd  = f_rd;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    assign valid = (count != '0);
    assign full  = (count == FULL_CNT);
    assign pop   = valid & dis_ready_in & rdy_in & ~clear_in;
    assign push  = fet_issue_in & rdy_in & ~clear_in & (~full | pop);

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy_in) begin
            if (clear_in) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) tail <= tail + PTR_W'(1);
                if (pop)  head <= head + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count <= count + (PTR_W+1)'(1);
                    2'b01:   count <= count - (PTR_W+1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in && push) mem[tail] <= dec;
    end

    assign head_ent = mem[head];

    assign fet_full_out        = full;
    assign fet_almost_full_out = (count >= AFULL_CNT);
    assign count_out           = count;
    assign dis_valid_out       = valid;
    assign dis_inst_out        = valid ? head_ent.inst       : '0;
    assign dis_pc_out          = valid ? head_ent.pc         : '0;
    assign dis_predict_pc_out  = valid ? head_ent.predict_pc : '0;
    assign dis_imm_out         = valid ? head_ent.imm        : '0;
    assign dis_class_out       = valid ? head_ent.cls        : '0;
    assign dis_rs1_out         = valid ? head_ent.rs1        : '0;
    assign dis_rs2_out         = valid ? head_ent.rs2        : '0;
    assign dis_rd_out          = valid ? head_ent.rd         : '0;
    assign dis_occupy_rd_out   = valid & (head_ent.rd != '0);
    assign dis_illegal_out     = valid & head_ent.illegal;

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: accepted pushes queue hand-decoded entries,
// a negedge monitor compares the head and occupancy every cycle.
module tb_inst_queue;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] ppc;
        logic [31:0] imm;
        logic [2:0]  cls;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        occ;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        issue = 1'b0;
    logic [31:0] inst = '0;
    logic [31:0] pc = '0;
    logic [31:0] ppc = '0;
    logic        full;
    logic        afull;
    logic        clear = 1'b0;
    logic        ready = 1'b0;
    logic        valid;
    logic [31:0] d_inst, d_pc, d_ppc, d_imm;
    logic [2:0]  d_cls;
    logic [4:0]  d_rs1, d_rs2, d_rd;
    logic        d_occ, d_ill;
    logic [4:0]  count;

    int   total = 0;
    int   bad = 0;
    int   mcount = 0;
    int   next_k = 1;
    bit   chk_en = 1'b0;
    exp_t cur;
    exp_t sb[$];

    inst_queue #(.DEPTH(16), .PTR_W(4)) dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
        .fet_issue_in(issue), .fet_inst_in(inst), .fet_pc_in(pc),
        .fet_predict_pc_in(ppc), .fet_full_out(full),
        .fet_almost_full_out(afull), .clear_in(clear),
        .dis_ready_in(ready), .dis_valid_out(valid), .dis_inst_out(d_inst),
        .dis_pc_out(d_pc), .dis_predict_pc_out(d_ppc), .dis_imm_out(d_imm),
        .dis_class_out(d_cls), .dis_rs1_out(d_rs1), .dis_rs2_out(d_rs2),
        .dis_rd_out(d_rd), .dis_occupy_rd_out(d_occ),
        .dis_illegal_out(d_ill), .count_out(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] i, input logic [31:0] p,
                                input logic [2:0] c, input logic [31:0] im,
                                input logic [4:0] r1, input logic [4:0] r2,
                                input logic [4:0] rd, input logic oc, input logic il);
        exp_t e;
        e.inst = i; e.pc = p; e.ppc = p + 32'd4; e.imm = im; e.cls = c;
        e.rs1 = r1; e.rs2 = r2; e.rd = rd; e.occ = oc; e.ill = il;
        return e;
    endfunction

    // Hand-decoded directed vectors covering every immediate format and mask rule.
    function automatic exp_t vec(input int n);
        logic [31:0] p;
        p = 32'h100 + 32'(n) * 32'd4;
        case (n)
            0:  return mk(32'hFFF30293, p, 3'd1, 32'hFFFFFFFF, 5'd6, 5'd0, 5'd5, 1'b1, 1'b0);
            1:  return mk(32'h0020A423, p, 3'd3, 32'h00000008, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
            2:  return mk(32'h002081B3, p, 3'd0, 32'h00000000, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
            3:  return mk(32'hFE208CE3, p, 3'd4, 32'hFFFFFFF8, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
            4:  return mk(32'h001000EF, p, 3'd5, 32'h00000800, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0);
            5:  return mk(32'h123453B7, p, 3'd7, 32'h12345000, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
            6:  return mk(32'hFFC12503, p, 3'd2, 32'hFFFFFFFC, 5'd2, 5'd0, 5'd10, 1'b1, 1'b0);
            7:  return mk(32'h00008067, p, 3'd6, 32'h00000000, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
            8:  return mk(32'hFFFFFFFF, p, 3'd0, 32'h00000000, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
            9:  return mk(32'hFFFFF217, p, 3'd7, 32'hFFFFF000, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0);
            default: return mk(32'hFE530FA3, p, 3'd3, 32'hFFFFFFFF, 5'd6, 5'd5, 5'd0, 1'b0, 1'b0);
        endcase
    endfunction

    // addi x1, x0, k with a distinct PC per k, used for ordering runs
    function automatic exp_t seq_ent(input int k);
        logic [11:0] k12;
        k12 = k[11:0];
        return mk({k12, 5'd0, 3'b000, 5'd1, 7'b0010011}, 32'h1000 + 32'(k) * 32'd4,
                  3'd1, 32'(k), 5'd0, 5'd0, 5'd1, 1'b1, 1'b0);
    endfunction

    task automatic drive(input exp_t e);
        cur = e;
        inst = e.inst;
        pc = e.pc;
        ppc = e.ppc;
    endtask

    task automatic drive_next();
        drive(seq_ent(next_k));
        next_k++;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference occupancy and push acceptance, updated on the same edge as the DUT.
    always @(posedge clk) begin
        bit mpop, mpush;
        if (!rst) begin
            sb.delete();
            mcount = 0;
        end else if (rdy) begin
            if (clear) begin
                sb.delete();
                mcount = 0;
            end else begin
                mpop  = (mcount != 0) && ready;
                mpush = issue && ((mcount != 16) || mpop);
                if (mpush) sb.push_back(cur);
                mcount = mcount + (mpush ? 1 : 0) - (mpop ? 1 : 0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (chk_en) begin
            chk("count", 32'(count), 32'(mcount));
            chk("full", 32'(full), 32'(mcount == 16));
            chk("almost_full", 32'(afull), 32'(mcount >= 15));
            chk("valid", 32'(valid), 32'(mcount != 0));
            if (mcount != 0 && sb.size() != 0) begin
                e = sb[0];
                chk("inst", d_inst, e.inst);
                chk("pc", d_pc, e.pc);
                chk("predict_pc", d_ppc, e.ppc);
                chk("imm", d_imm, e.imm);
                chk("class", 32'(d_cls), 32'(e.cls));
                chk("rs1", 32'(d_rs1), 32'(e.rs1));
                chk("rs2", 32'(d_rs2), 32'(e.rs2));
                chk("rd", 32'(d_rd), 32'(e.rd));
                chk("occupy_rd", 32'(d_occ), 32'(e.occ));
                chk("illegal", 32'(d_ill), 32'(e.ill));
                if (ready && rdy && !clear && rst) void'(sb.pop_front());
            end else begin
                chk("idle_outputs_zero",
                    d_inst | d_pc | d_ppc | d_imm | 32'(d_cls) | 32'(d_rs1) |
                    32'(d_rs2) | 32'(d_rd) | 32'(d_occ) | 32'(d_ill), 32'h0);
            end
        end
    end

    initial begin
        cycle();
        chk_en = 1'b1;
        cycle();
        rst = 1'b1;

        // directed decode vectors, streaming through with dispatch ready
        ready = 1'b1;
        for (int n = 0; n < 11; n++) begin
            drive(vec(n));
            issue = 1'b1;
            cycle();
        end
        issue = 1'b0;
        repeat (3) cycle();

        // fill with 17 pushes while stalled, then drain in order
        ready = 1'b0;
        for (int n = 0; n < 17; n++) begin
            drive_next();
            issue = 1'b1;
            cycle();
            if (n == 14) chk("almost_full_at_15", 32'(afull), 32'd1);
            if (n == 14) chk("not_full_at_15", 32'(full), 32'd0);
        end
        issue = 1'b0;
        chk("count_after_17_pushes", 32'(count), 32'd16);
        chk("full_after_17_pushes", 32'(full), 32'd1);
        ready = 1'b1;
        repeat (18) cycle();
        chk("count_after_drain", 32'(count), 32'd0);

        // full queue with push and pop every cycle across pointer wrap
        ready = 1'b0;
        for (int n = 0; n < 16; n++) begin
            drive_next();
            issue = 1'b1;
            cycle();
        end
        ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            drive_next();
            cycle();
        end
        issue = 1'b0;
        chk("count_steady_full", 32'(count), 32'd16);
        repeat (18) cycle();

        // flush beats concurrent push; next push appears alone
        ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            drive_next();
            issue = 1'b1;
            cycle();
        end
        drive_next();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        issue = 1'b0;
        chk("count_after_clear", 32'(count), 32'd0);
        chk("valid_after_clear", 32'(valid), 32'd0);
        drive_next();
        issue = 1'b1;
        cycle();
        issue = 1'b0;
        chk("count_single_after_clear", 32'(count), 32'd1);
        ready = 1'b1;
        repeat (3) cycle();

        // global stall holds everything even with push and pop requested
        ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            drive_next();
            issue = 1'b1;
            cycle();
        end
        rdy = 1'b0;
        ready = 1'b1;
        repeat (4) begin
            drive_next();
            cycle();
        end
        chk("count_held_stalled", 32'(count), 32'd3);
        issue = 1'b0;
        rdy = 1'b1;
        repeat (5) cycle();

        // reset while holding 7 entries and stalled
        ready = 1'b0;
        for (int n = 0; n < 7; n++) begin
            drive_next();
            issue = 1'b1;
            cycle();
        end
        chk("count_before_reset", 32'(count), 32'd7);
        rdy = 1'b0;
        rst = 1'b0;
        cycle();
        chk("count_after_reset", 32'(count), 32'd0);
        chk("valid_after_reset", 32'(valid), 32'd0);
        chk("full_after_reset", 32'(full | afull), 32'd0);
        issue = 1'b0;
        rst = 1'b1;
        rdy = 1'b1;
        drive_next();
        issue = 1'b1;
        cycle();
        issue = 1'b0;
        ready = 1'b1;
        repeat (4) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
